// File: rtl/high_score_tracker_if.sv
// Game-side signals of the high score tracker: the game level and score coming in, the record outputs going out.
// The master modport is the driver of game/score; the slave modport is the tracker itself.
interface high_score_tracker_if #(
    parameter int MAX_SCORE = 9999
);
    localparam int SCORE_W = $clog2(MAX_SCORE);

    logic               game_in_progress;
    logic [SCORE_W-1:0] score;
    logic [SCORE_W-1:0] high_score;
    logic               new_record;
    logic               record_blink;
    logic [7:0]         games_played;

    modport master (
        output game_in_progress,
        output score,
        input  high_score,
        input  new_record,
        input  record_blink,
        input  games_played
    );

    modport slave (
        input  game_in_progress,
        input  score,
        output high_score,
        output new_record,
        output record_blink,
        output games_played
    );
endinterface

// File: rtl/high_score_tracker.sv
// Keeps the best score since power-on; record updates SETTLE_CYCLES+1 edges after game end, then blinks the display.
// All outputs registered; no backpressure, a new game start aborts any blink in progress.
module high_score_tracker #(
    parameter int MAX_SCORE       = 9999,
    parameter int CLKS_PER_MS     = 50000,
    parameter int BLINK_PERIOD_MS = 250,
    parameter int NUM_BLINKS      = 6,
    parameter int SETTLE_CYCLES   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    high_score_tracker_if.slave  bus
);
    localparam int SCORE_W   = $clog2(MAX_SCORE);
    localparam int PHASE_LEN = BLINK_PERIOD_MS * CLKS_PER_MS;
    localparam int PH_W      = (PHASE_LEN > 1) ? $clog2(PHASE_LEN) : 1;
    localparam int TG_W      = $clog2(2 * NUM_BLINKS + 1);
    localparam int ST_W      = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [PH_W-1:0]    PH_TERM = PH_W'(PHASE_LEN - 1);
    localparam logic [TG_W-1:0]    TG_LAST = TG_W'(2 * NUM_BLINKS);
    localparam logic [ST_W-1:0]    ST_TERM = ST_W'(SETTLE_CYCLES - 1);
    localparam logic [SCORE_W-1:0] MAX_S   = SCORE_W'(MAX_SCORE);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PLAYING = 3'd1,
        SETTLE  = 3'd2,
        COMPARE = 3'd3,
        BLINK   = 3'd4
    } state_t;

    state_t               r_state,        w_state_nxt;
    logic [ST_W-1:0]      r_settle_cnt,   w_settle_cnt_nxt;
    logic [PH_W-1:0]      r_phase_cnt,    w_phase_cnt_nxt;
    logic [TG_W-1:0]      r_toggle_cnt,   w_toggle_cnt_nxt;
    logic [SCORE_W-1:0]   r_high_score,   w_high_score_nxt;
    logic                 r_new_record,   w_new_record_nxt;
    logic                 r_record_blink, w_record_blink_nxt;
    logic [7:0]           r_games_played, w_games_played_nxt;

    logic [SCORE_W-1:0]   w_clamped;
    logic [7:0]           w_games_inc;
    logic [TG_W-1:0]      w_toggle_inc;

    assign w_clamped    = (bus.score > MAX_S) ? MAX_S : bus.score;
    assign w_games_inc  = (r_games_played == 8'hFF) ? r_games_played : r_games_played + 8'd1;
    assign w_toggle_inc = r_toggle_cnt + TG_W'(1);

    always_comb begin
        w_state_nxt        = r_state;
        w_settle_cnt_nxt   = r_settle_cnt;
        w_phase_cnt_nxt    = r_phase_cnt;
        w_toggle_cnt_nxt   = r_toggle_cnt;
        w_high_score_nxt   = r_high_score;
        w_new_record_nxt   = 1'b0;
        w_record_blink_nxt = r_record_blink;
        w_games_played_nxt = r_games_played;
        case (r_state)
            IDLE: begin
                if (bus.game_in_progress) begin
                    w_state_nxt        = PLAYING;
                    w_games_played_nxt = w_games_inc;
                end
            end
            PLAYING: begin
                if (!bus.game_in_progress) begin
                    w_state_nxt      = SETTLE;
                    w_settle_cnt_nxt = '0;
                end
            end
            SETTLE: begin
                w_settle_cnt_nxt = r_settle_cnt + ST_W'(1);
                if (r_settle_cnt == ST_TERM) begin
                    w_state_nxt = COMPARE;
                end
            end
            COMPARE: begin
                // Strict compare: ties and a zero score never count as a record.
                if (w_clamped > r_high_score) begin
                    w_high_score_nxt   = w_clamped;
                    w_new_record_nxt   = 1'b1;
                    w_record_blink_nxt = 1'b1;
                    w_phase_cnt_nxt    = '0;
                    w_toggle_cnt_nxt   = '0;
                    w_state_nxt        = BLINK;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            BLINK: begin
                if (bus.game_in_progress) begin
                    w_record_blink_nxt = 1'b0;
                    w_games_played_nxt = w_games_inc;
                    w_state_nxt        = PLAYING;
                end else if (r_phase_cnt == PH_TERM) begin
                    w_phase_cnt_nxt  = '0;
                    w_toggle_cnt_nxt = w_toggle_inc;
                    if (w_toggle_inc == TG_LAST) begin
                        w_record_blink_nxt = 1'b0;
                        w_state_nxt        = IDLE;
                    end else begin
                        w_record_blink_nxt = ~r_record_blink;
                    end
                end else begin
                    w_phase_cnt_nxt = r_phase_cnt + PH_W'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_settle_cnt   <= '0;
            r_phase_cnt    <= '0;
            r_toggle_cnt   <= '0;
            r_high_score   <= '0;
            r_new_record   <= 1'b0;
            r_record_blink <= 1'b0;
            r_games_played <= 8'd0;
        end else begin
            r_state        <= w_state_nxt;
            r_settle_cnt   <= w_settle_cnt_nxt;
            r_phase_cnt    <= w_phase_cnt_nxt;
            r_toggle_cnt   <= w_toggle_cnt_nxt;
            r_high_score   <= w_high_score_nxt;
            r_new_record   <= w_new_record_nxt;
            r_record_blink <= w_record_blink_nxt;
            r_games_played <= w_games_played_nxt;
        end
    end

    assign bus.high_score   = r_high_score;
    assign bus.new_record   = r_new_record;
    assign bus.record_blink = r_record_blink;
    assign bus.games_played = r_games_played;
endmodule

// File: tb/tb_high_score_tracker.sv
// Directed-vector bench for high_score_tracker with short blink timing (4-cycle phases, 2 blinks, 2 settle cycles).
module tb_high_score_tracker;
    localparam int ST_IDLE    = 0;
    localparam int ST_PLAYING = 1;
    localparam int ST_BLINK   = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    high_score_tracker_if #(.MAX_SCORE(9999)) bus ();

    high_score_tracker #(
        .MAX_SCORE       (9999),
        .CLKS_PER_MS     (2),
        .BLINK_PERIOD_MS (2),
        .NUM_BLINKS      (2),
        .SETTLE_CYCLES   (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check_val(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, "_high"},  int'(bus.high_score),   0);
        check_val({tag, "_nrec"},  int'(bus.new_record),   0);
        check_val({tag, "_blink"}, int'(bus.record_blink), 0);
        check_val({tag, "_games"}, int'(bus.games_played), 0);
        check_val({tag, "_state"}, int'(dut.r_state),      ST_IDLE);
    endtask

    // Plays one game of len cycles then returns just after E3 (the COMPARE edge).
    task automatic end_game(input int sc, input int len);
        bus.game_in_progress = 1'b1;
        bus.score            = 14'(sc);
        repeat (len) tick();
        bus.game_in_progress = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        int exp_blink;
        rst                  = 1'b1;
        bus.game_in_progress = 1'b0;
        bus.score            = '0;
        repeat (2) tick();
        check_zero("reset");
        rst = 1'b0;
        repeat (3) tick();
        check_val("idle_games", int'(bus.games_played), 0);

        // First record: 37 after a 10-cycle game, then full blink sequence.
        end_game(37, 10);
        check_val("rec1_high",  int'(bus.high_score),   37);
        check_val("rec1_nrec",  int'(bus.new_record),   1);
        check_val("rec1_blink", int'(bus.record_blink), 1);
        check_val("rec1_games", int'(bus.games_played), 1);
        for (int i = 1; i <= 17; i++) begin
            tick();
            if (i == 1) check_val("rec1_nrec_fall", int'(bus.new_record), 0);
            exp_blink = ((i < 4) || (i >= 8 && i < 12)) ? 1 : 0;
            check_val($sformatf("rec1_blink_c%0d", i), int'(bus.record_blink), exp_blink);
        end
        check_val("rec1_done_state", int'(dut.r_state), ST_IDLE);

        // Tie and lower scores leave the record alone.
        end_game(37, 3);
        check_val("tie_high",  int'(bus.high_score),   37);
        check_val("tie_nrec",  int'(bus.new_record),   0);
        check_val("tie_blink", int'(bus.record_blink), 0);
        tick();
        check_val("tie_state", int'(dut.r_state), ST_IDLE);
        end_game(20, 3);
        check_val("low_high",  int'(bus.high_score),   37);
        check_val("low_nrec",  int'(bus.new_record),   0);
        check_val("low_blink", int'(bus.record_blink), 0);
        check_val("low_games", int'(bus.games_played), 3);
        tick();

        // Score settles one cycle after the game ends.
        bus.game_in_progress = 1'b1;
        bus.score            = 14'd50;
        repeat (3) tick();
        bus.game_in_progress = 1'b0;
        tick();
        bus.score = 14'd52;
        repeat (3) tick();
        check_val("late_high",  int'(bus.high_score),   52);
        check_val("late_nrec",  int'(bus.new_record),   1);
        check_val("late_games", int'(bus.games_played), 4);

        // Abort the blink with a new game, then a clamped score.
        repeat (2) tick();
        check_val("abort_pre_blink", int'(bus.record_blink), 1);
        bus.game_in_progress = 1'b1;
        tick();
        check_val("abort_blink", int'(bus.record_blink), 0);
        check_val("abort_state", int'(dut.r_state),      ST_PLAYING);
        check_val("abort_games", int'(bus.games_played), 5);
        bus.score = 14'd12000;
        tick();
        bus.game_in_progress = 1'b0;
        repeat (4) tick();
        check_val("clamp_high", int'(bus.high_score), 9999);
        check_val("clamp_nrec", int'(bus.new_record), 1);
        repeat (20) tick();
        check_val("clamp_done_state", int'(dut.r_state),      ST_IDLE);
        check_val("clamp_done_blink", int'(bus.record_blink), 0);

        // 256 short zero-score games saturate the game counter.
        for (int g = 0; g < 256; g++) begin
            bus.game_in_progress = 1'b1;
            bus.score            = '0;
            tick();
            bus.game_in_progress = 1'b0;
            repeat (4) tick();
        end
        check_val("sat_games", int'(bus.games_played), 255);
        check_val("sat_high",  int'(bus.high_score),   9999);

        // Reset clears the record; then reset in the middle of a blink.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_zero("rst2");
        end_game(5, 2);
        check_val("rst_pre_high",  int'(bus.high_score),   5);
        check_val("rst_pre_state", int'(dut.r_state),      ST_BLINK);
        check_val("rst_pre_blink", int'(bus.record_blink), 1);
        tick();
        rst = 1'b1;
        tick();
        check_zero("rst_blink");
        rst = 1'b0;
        tick();
        check_zero("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/high_score_tracker.md
# high_score_tracker

Tracks the best score across games. Sits downstream of `score_counter` and alongside the FSM's `game_in_progress` output. At each game end it waits for the final score to settle, compares it with the stored high score and updates the record. On a new record it pulses a flag and drives a timed blink pattern for the score display. Its reset is a power-on/system reset, not the per-game reset button, so the record survives between games.

## Interface
Parameters:
- `MAX_SCORE`, 9999: largest legal score; incoming scores above it are clamped.
- `CLKS_PER_MS`, 50000: clock cycles per millisecond.
- `BLINK_PERIOD_MS`, 250: duration of each blink phase (on or off).
- `NUM_BLINKS`, 6: number of on/off pairs shown after a new record.
- `SETTLE_CYCLES`, 2: cycles to wait after game end before sampling `score`.
- Derived localparam `SCORE_W` = `$clog2(MAX_SCORE)`.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `game_in_progress`  in  1  level, high while a game runs.
- `score`  in  SCORE_W  current score from `score_counter`.
- `high_score`  out  SCORE_W  best score recorded since reset.
- `new_record`  out  1  one-cycle pulse when `high_score` is replaced.
- `record_blink`  out  1  blink level for the display; 0 when not blinking.
- `games_played`  out  8  count of games started, saturating at 255.

## Operation
- Reset values: `high_score`=0, `new_record`=0, `record_blink`=0, `games_played`=0, state=IDLE, all counters 0.
- States: IDLE, PLAYING, SETTLE, COMPARE, BLINK.
- IDLE:
  - `game_in_progress`=1 -> PLAYING.
  - `games_played` increments by 1 on this transition, holding at 255.
- PLAYING:
  - `game_in_progress`=0 -> SETTLE.
  - The settle counter is cleared on this transition.
- SETTLE:
  - The counter increments each cycle.
  - When the counter reaches SETTLE_CYCLES-1, go to COMPARE.
  - `game_in_progress` is ignored in this state.
- COMPARE (one cycle):
  - Compute `s` = min(`score`, MAX_SCORE).
  - If `s` > `high_score`: `high_score`<=`s`, `new_record`<=1, `record_blink`<=1, go to BLINK, and clear the blink counters.
  - Otherwise go to IDLE.
  - A tie is not a record. A score of 0 never sets a record.
- BLINK:
  - The phase counter counts to BLINK_PERIOD_MS*CLKS_PER_MS-1.
  - At terminal count, `record_blink` toggles and the toggle counter increments.
  - After 2*NUM_BLINKS toggles, `record_blink` is 0 and the state returns to IDLE.
  - `game_in_progress`=1 at any cycle aborts the blink: `record_blink`<=0, go to PLAYING, and `games_played` increments as from IDLE.
- `new_record` is 1 for exactly one cycle: the cycle after the COMPARE edge.
- Width rules:
  - Phase counter width is `$clog2(BLINK_PERIOD_MS*CLKS_PER_MS)`.
  - Toggle counter width is `$clog2(2*NUM_BLINKS+1)`.
  - `games_played` never wraps.
- Reset mid-operation in any state returns all outputs to their reset values on the next edge; the record is lost.

## Timing
- Let E0 be the first edge sampling `game_in_progress`=0 in PLAYING.
  - With SETTLE_CYCLES=2, the state is SETTLE after E0 and E1, and COMPARE after E2.
  - `score` is sampled at E3.
  - `high_score` and `new_record` are visible after E3.
  - `new_record` falls after E4.
- Total latency from game end to the updated record is SETTLE_CYCLES+1 edges after E0. Score updates landing up to SETTLE_CYCLES-1 cycles late are captured.
- First blink phase: `record_blink`=1 from E3 for BLINK_PERIOD_MS*CLKS_PER_MS cycles, then alternates. Total blink time is 2*NUM_BLINKS*BLINK_PERIOD_MS*CLKS_PER_MS cycles.
- `games_played` updates on the edge that leaves IDLE or BLINK.
- All outputs are registered; there are no combinational paths from input to output.

## Test plan
Bench parameters: CLKS_PER_MS=2, BLINK_PERIOD_MS=2, NUM_BLINKS=2, SETTLE_CYCLES=2.
- **Reset state:** assert `rst` for 2 cycles -> all outputs are 0 and the state is IDLE; `games_played` stays 0 while `game_in_progress`=0.
- **First record:**
  - Stimulus: game high for 10 cycles, `score`=37, then game low.
  - `high_score`=37 and `new_record`=1 for exactly 1 cycle, 3 edges after E0.
  - `record_blink` runs 1,0,1,0 in 4-cycle phases, then 0 in IDLE.
  - `games_played`=1.
- **Tie and lower scores:**
  - Second game ends with `score`=37 -> `high_score` stays 37, no pulse, no blink.
  - Third game ends with `score`=20 -> same result.
  - `games_played`=3.
- **Late score settle:** `score` changes from 50 to 52 one cycle after the game ends -> `high_score`=52.
- **Abort and clamp:**
  - During a blink, raise `game_in_progress` -> `record_blink`=0 next cycle, state PLAYING, `games_played` increments.
  - Then end with `score`=12000 -> `high_score`=9999.
- **Saturation and reset:**
  - 256 short games -> `games_played` holds at 255.
  - Assert `rst` during BLINK -> all outputs are 0 next cycle.
